// File: rtl/immed_encoder.sv
// ---------------------------------------------------------------------------
// immed_encoder
//
// Purpose:
//   Packs a 32-bit immediate into the I/S/B/U/J immediate bit positions of a
//   RISC-V instruction template. This is the inverse of the core's immediate
//   decode. It also flags immediates that cannot be represented in the chosen
//   format. The boot/debug loader uses it to patch branch, jump and load
//   offsets before they are written into instruction memory.
//
//   There are two pipeline stages with valid/ready handshakes:
//     stage 1 - registers the request (fmt, base, imm), then derives the
//               range, alignment and format error flags from the registered
//               copy.
//     stage 2 - registers the encoded word and its flags, and holds both
//               stable while the consumer stalls.
//   Errors never block the pipeline. The truncated encoding is still emitted,
//   with its flags set. err_count is a saturating count of the delivered
//   words that carry any error flag.
//
// Optional feature (macro IMMED_ROUNDTRIP_EN):
//   When the macro is defined, stage 2 decodes the encoded word back into a
//   sign-extended immediate and raises rt_err if that value differs from the
//   registered imm. The check only applies to legal requests that have no
//   range or alignment error. rt_err also counts towards err_count.
//   When the macro is undefined, rt_err is tied to 0 and no extra logic is
//   built.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   request valid
//   in_ready   out  encoder can accept a request this cycle
//   fmt        in   0=I 1=S 2=B 3=U 4=J, 5-7 illegal
//   base       in   instruction template; immediate bit positions overwritten
//   imm        in   immediate (byte offset for B/J, full upper value for U)
//   out_valid  out  encoded word valid
//   out_ready  in   consumer accepts the word
//   instr      out  encoded instruction
//   range_err  out  imm not representable in fmt
//   align_err  out  required-zero low bits of imm are nonzero
//   fmt_err    out  illegal fmt
//   rt_err     out  round-trip decode mismatch (optional feature)
//   err_count  out  saturating count of delivered words with any error flag
// ---------------------------------------------------------------------------
module immed_encoder #(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           fmt,
  input  logic [31:0]          base,
  input  logic [31:0]          imm,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          instr,
  output logic                 range_err,
  output logic                 align_err,
  output logic                 fmt_err,
  output logic                 rt_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  typedef enum logic [2:0] {
    FMT_I = 3'd0,
    FMT_S = 3'd1,
    FMT_B = 3'd2,
    FMT_U = 3'd3,
    FMT_J = 3'd4
  } fmt_e;

  localparam logic [ERR_CNT_W-1:0] CNT_MAX = {ERR_CNT_W{1'b1}};
  localparam logic [ERR_CNT_W-1:0] CNT_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

  // Stage 1 registers
  logic        s1_valid_q, s1_valid_d;
  logic [2:0]  s1_fmt_q,   s1_fmt_d;
  logic [31:0] s1_base_q,  s1_base_d;
  logic [31:0] s1_imm_q,   s1_imm_d;

  // Stage 2 registers
  logic                 out_valid_q, out_valid_d;
  logic [31:0]          instr_q,     instr_d;
  logic                 range_err_q, range_err_d;
  logic                 align_err_q, align_err_d;
  logic                 fmt_err_q,   fmt_err_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

  // Stage 1 combinational results
  logic        s1_adv;
  logic        range_err_c;
  logic        align_err_c;
  logic        fmt_err_c;
  logic [31:0] instr_c;
  logic        any_err;

  // ------------------------------------------------------------------------
  // Handshake. Stage 2 can take a new word when it is empty or when its
  // current word is leaving this cycle. Stage 1 can take a request when it
  // is empty or when it is passing its word on. in_ready does not depend on
  // in_valid, so there is no combinational path from in_valid to out_valid.
  // ------------------------------------------------------------------------
  always_comb begin
    s1_adv   = !out_valid_q || out_ready;
    in_ready = !s1_valid_q || s1_adv;
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_fmt_d   = s1_fmt_q;
    s1_base_d  = s1_base_q;
    s1_imm_d   = s1_imm_q;
    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_fmt_d  = fmt;
        s1_base_d = base;
        s1_imm_d  = imm;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_fmt_q   <= 3'd0;
      s1_base_q  <= 32'd0;
      s1_imm_q   <= 32'd0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_fmt_q   <= s1_fmt_d;
      s1_base_q  <= s1_base_d;
      s1_imm_q   <= s1_imm_d;
    end
  end

  // ------------------------------------------------------------------------
  // Representability checks. An immediate fits an N-bit signed field when
  // every bit above the field's sign bit is a copy of that sign bit. The
  // "not all equal" tests below catch any other pattern. U-type keeps only
  // imm[31:12], so nonzero low bits are reported as an alignment error.
  // ------------------------------------------------------------------------
  always_comb begin
    range_err_c = 1'b0;
    align_err_c = 1'b0;
    fmt_err_c   = 1'b0;
    case (s1_fmt_q)
      FMT_I, FMT_S: begin
        range_err_c = !((&s1_imm_q[31:11]) || !(|s1_imm_q[31:11]));
      end
      FMT_B: begin
        range_err_c = !((&s1_imm_q[31:12]) || !(|s1_imm_q[31:12]));
        align_err_c = s1_imm_q[0];
      end
      FMT_U: begin
        align_err_c = |s1_imm_q[11:0];
      end
      FMT_J: begin
        range_err_c = !((&s1_imm_q[31:20]) || !(|s1_imm_q[31:20]));
        align_err_c = s1_imm_q[0];
      end
      default: begin
        fmt_err_c = 1'b1;
      end
    endcase
  end

  // ------------------------------------------------------------------------
  // Scatter the immediate into the template. B and J drop imm[0] because
  // targets are halfword aligned. Their sign bit always lands in instr[31].
  // An illegal format passes the template through unchanged.
  // ------------------------------------------------------------------------
  always_comb begin
    instr_c = s1_base_q;
    case (s1_fmt_q)
      FMT_I: begin
        instr_c[31:20] = s1_imm_q[11:0];
      end
      FMT_S: begin
        instr_c[31:25] = s1_imm_q[11:5];
        instr_c[11:7]  = s1_imm_q[4:0];
      end
      FMT_B: begin
        instr_c[31]    = s1_imm_q[12];
        instr_c[30:25] = s1_imm_q[10:5];
        instr_c[11:8]  = s1_imm_q[4:1];
        instr_c[7]     = s1_imm_q[11];
      end
      FMT_U: begin
        instr_c[31:12] = s1_imm_q[31:12];
      end
      FMT_J: begin
        instr_c[31]    = s1_imm_q[20];
        instr_c[30:21] = s1_imm_q[10:1];
        instr_c[20]    = s1_imm_q[11];
        instr_c[19:12] = s1_imm_q[19:12];
      end
      default: begin
        instr_c = s1_base_q;
      end
    endcase
  end

`ifdef IMMED_ROUNDTRIP_EN
  logic [31:0] rt_imm_c;
  logic        rt_err_c;
  logic        rt_err_q, rt_err_d;

  // ------------------------------------------------------------------------
  // Decode the encoded word the same way the core's decoder will. This
  // catches any disagreement between the encode mapping and what the core
  // will actually execute. Requests that already carry a range or alignment
  // error are skipped, because their truncated encoding is expected to
  // differ from imm.
  // ------------------------------------------------------------------------
  always_comb begin
    rt_imm_c = 32'd0;
    case (s1_fmt_q)
      FMT_I: rt_imm_c = {{20{instr_c[31]}}, instr_c[31:20]};
      FMT_S: rt_imm_c = {{20{instr_c[31]}}, instr_c[31:25], instr_c[11:7]};
      FMT_B: rt_imm_c = {{19{instr_c[31]}}, instr_c[31], instr_c[7],
                         instr_c[30:25], instr_c[11:8], 1'b0};
      FMT_U: rt_imm_c = {instr_c[31:12], 12'd0};
      FMT_J: rt_imm_c = {{11{instr_c[31]}}, instr_c[31], instr_c[19:12],
                         instr_c[20], instr_c[30:21], 1'b0};
      default: rt_imm_c = s1_imm_q;
    endcase
    rt_err_c = !fmt_err_c && !range_err_c && !align_err_c &&
               (rt_imm_c != s1_imm_q);
  end

  always_comb begin
    rt_err_d = rt_err_q;
    if (s1_adv && s1_valid_q) begin
      rt_err_d = rt_err_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rt_err_q <= 1'b0;
    end else begin
      rt_err_q <= rt_err_d;
    end
  end

  assign rt_err  = rt_err_q;
  assign any_err = range_err_q || align_err_q || fmt_err_q || rt_err_q;
`else
  assign rt_err  = 1'b0;
  assign any_err = range_err_q || align_err_q || fmt_err_q;
`endif

  // ------------------------------------------------------------------------
  // Stage 2 loads only when it is free to advance, so a stalled word and its
  // flags stay frozen. A bubble clears out_valid but leaves the stale data,
  // because the data is only meaningful while out_valid is high.
  // ------------------------------------------------------------------------
  always_comb begin
    out_valid_d = out_valid_q;
    instr_d     = instr_q;
    range_err_d = range_err_q;
    align_err_d = align_err_q;
    fmt_err_d   = fmt_err_q;
    if (s1_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        instr_d     = instr_c;
        range_err_d = range_err_c;
        align_err_d = align_err_c;
        fmt_err_d   = fmt_err_c;
      end
    end
  end

  // Count a word only when it is actually handed over, and stop at all-ones.
  always_comb begin
    err_count_d = err_count_q;
    if (out_valid_q && out_ready && any_err && (err_count_q != CNT_MAX)) begin
      err_count_d = err_count_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      instr_q     <= 32'd0;
      range_err_q <= 1'b0;
      align_err_q <= 1'b0;
      fmt_err_q   <= 1'b0;
      err_count_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      instr_q     <= instr_d;
      range_err_q <= range_err_d;
      align_err_q <= align_err_d;
      fmt_err_q   <= fmt_err_d;
      err_count_q <= err_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign instr     = instr_q;
  assign range_err = range_err_q;
  assign align_err = align_err_q;
  assign fmt_err   = fmt_err_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_immed_encoder.sv
// ---------------------------------------------------------------------------
// tb_immed_encoder
//
// Directed bench for immed_encoder. Requests are driven after the rising
// edge. Everything is observed on the falling edge. Each accepted request is
// pushed into a queue of expected words that a reference model computes from
// the format rules with plain arithmetic. Every delivered word is popped and
// compared. err_count is compared against a saturating counter kept by the
// bench. Directed cases also carry hand-computed literal results.
// ---------------------------------------------------------------------------
module tb_immed_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  fmt;
  logic [31:0] base;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic        range_err;
  logic        align_err;
  logic        fmt_err;
  logic        rt_err;
  logic [7:0]  err_count;

  typedef struct packed {
    logic [31:0] instr;
    logic        r;
    logic        a;
    logic        f;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   last_acc_cyc = 0;
  int   model_cnt = 0;
  int   delivered = 0;
  int   acc_n = 0;

  immed_encoder #(.ERR_CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .base(base), .imm(imm), .out_valid(out_valid),
    .out_ready(out_ready), .instr(instr), .range_err(range_err),
    .align_err(align_err), .fmt_err(fmt_err), .rt_err(rt_err),
    .err_count(err_count)
  );

  // Free-running clock and cycle counter used for latency measurements.
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Single comparison point: every comparison steps the shared counters.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, act, req);
    end
  endtask

  task automatic timeoutFail(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: timed out waiting on DUT", name);
  endtask

  // Reference model. Range checks use signed bounds, and fields are placed
  // with masks and shifts.
  function automatic exp_t model(input logic [2:0] f, input logic [31:0] b,
                                 input logic [31:0] i);
    exp_t e;
    int   si;
    si = int'($signed(i));
    e = '0;
    case (f)
      3'd0: begin
        e.r = (si < -2048) || (si > 2047);
        e.instr = (b & 32'h000FFFFF) | ((i & 32'hFFF) << 20);
      end
      3'd1: begin
        e.r = (si < -2048) || (si > 2047);
        e.instr = (b & 32'h01FFF07F) | (((i >> 5) & 32'h7F) << 25) |
                  ((i & 32'h1F) << 7);
      end
      3'd2: begin
        e.r = (si < -4096) || (si > 4095);
        e.a = (i % 2) != 0;
        e.instr = (b & 32'h01FFF07F) | (((i >> 12) & 32'h1) << 31) |
                  (((i >> 5) & 32'h3F) << 25) | (((i >> 1) & 32'hF) << 8) |
                  (((i >> 11) & 32'h1) << 7);
      end
      3'd3: begin
        e.a = (i % 4096) != 0;
        e.instr = (b & 32'h00000FFF) | (i & 32'hFFFFF000);
      end
      3'd4: begin
        e.r = (si < -1048576) || (si > 1048575);
        e.a = (i % 2) != 0;
        e.instr = (b & 32'h00000FFF) | (((i >> 20) & 32'h1) << 31) |
                  (((i >> 1) & 32'h3FF) << 21) | (((i >> 11) & 32'h1) << 20) |
                  (i & 32'h000FF000);
      end
      default: begin
        e.f = 1'b1;
        e.instr = b;
      end
    endcase
    return e;
  endfunction

  // Compare process. While out_valid is high, it checks deliveries against
  // the queue, checks that stalled words stay stable, and tracks err_count.
  logic        stall_prev = 1'b0;
  logic [31:0] prev_instr = 32'd0;
  logic [2:0]  prev_flags = 3'd0;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      model_cnt = 0;
      stall_prev = 1'b0;
    end else begin
      checkOutput("err_count", {24'd0, err_count}, model_cnt);
      if (stall_prev) begin
        checkOutput("stall_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("stall_instr", instr, prev_instr);
        checkOutput("stall_flags", {29'd0, range_err, align_err, fmt_err},
                    {29'd0, prev_flags});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_word: got 0x%08h, want none", instr);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          delivered++;
          checkOutput("sb_instr", instr, e.instr);
          checkOutput("sb_flags", {28'd0, range_err, align_err, fmt_err, rt_err},
                      {28'd0, e.r, e.a, e.f, 1'b0});
          if ((e.r || e.a || e.f) && model_cnt < 255) model_cnt++;
        end
      end
      stall_prev = out_valid && !out_ready;
      prev_instr = instr;
      prev_flags = {range_err, align_err, fmt_err};
      if (in_valid && in_ready) exp_q.push_back(model(fmt, base, imm));
    end
  end

  // Present one request (entered just after a rising edge) and hold it until
  // it is accepted. Returns just after the accepting edge.
  task automatic streamReq(input logic [2:0] f, input logic [31:0] b,
                           input logic [31:0] i, output bit ok);
    fmt = f;
    base = b;
    imm = i;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        last_acc_cyc = cyc;
        break;
      end
    end
    if (!ok) begin
      timeoutFail("accept");
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
    end
  endtask

  // Send a single request and wait for its word. Checks the 2-cycle latency
  // and returns on the falling edge where the word is visible.
  task automatic applyStimulus(input logic [2:0] f, input logic [31:0] b,
                               input logic [31:0] i);
    bit ok;
    bit seen;
    streamReq(f, b, i, ok);
    in_valid = 1'b0;
    seen = 1'b0;
    if (ok) begin
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        if (out_valid) begin
          seen = 1'b1;
          break;
        end
      end
      if (!seen) timeoutFail("out_valid");
      else checkOutput("latency", cyc - last_acc_cyc, 32'd2);
    end
  endtask

  // Hand-computed expectations for the word currently on the output.
  task automatic checkWord(input string name, input logic [31:0] w,
                           input logic r, input logic a, input logic f);
    checkOutput({name, "_instr"}, instr, w);
    checkOutput({name, "_flags"}, {28'd0, range_err, align_err, fmt_err, rt_err},
                {28'd0, r, a, f, 1'b0});
    @(posedge clk);
    #1;
  endtask

  task automatic checkCount(input string name, input logic [31:0] n);
    @(negedge clk);
    checkOutput(name, {24'd0, err_count}, n);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) timeoutFail("drain");
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit ok;
    int d0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    fmt = 3'd0;
    base = 32'd0;
    imm = 32'd0;

    // Reset state, observed before any clock edge
    #2;
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_instr", instr, 32'd0);
    checkOutput("rst_flags", {28'd0, range_err, align_err, fmt_err, rt_err}, 32'd0);
    checkOutput("rst_err_count", {24'd0, err_count}, 32'd0);
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Legal encodings of each format
    applyStimulus(3'd0, 32'h00000093, 32'hFFFFFFFF);
    checkWord("i_addi", 32'hFFF00093, 1'b0, 1'b0, 1'b0);
    applyStimulus(3'd2, 32'h00000063, 32'h00000008);
    checkWord("b_fwd", 32'h00000463, 1'b0, 1'b0, 1'b0);
    applyStimulus(3'd4, 32'h000000EF, 32'h00000800);
    checkWord("j_bit11", 32'h001000EF, 1'b0, 1'b0, 1'b0);
    applyStimulus(3'd3, 32'h000000B7, 32'h12345000);
    checkWord("u_lui", 32'h123450B7, 1'b0, 1'b0, 1'b0);
    applyStimulus(3'd1, 32'h00112023, 32'h000007FF);
    checkWord("s_max", 32'h7E112FA3, 1'b0, 1'b0, 1'b0);
    applyStimulus(3'd2, 32'h00000063, 32'hFFFFF000);
    checkWord("b_min", 32'h80000063, 1'b0, 1'b0, 1'b0);

    // Error cases: the truncated encoding is still emitted
    applyStimulus(3'd0, 32'h00000093, 32'h00000800);
    checkWord("i_range", 32'h80000093, 1'b1, 1'b0, 1'b0);
    applyStimulus(3'd6, 32'hDEADBEEF, 32'h00000004);
    checkWord("fmt_ill", 32'hDEADBEEF, 1'b0, 1'b0, 1'b1);
    checkCount("cnt_two", 32'd2);
    applyStimulus(3'd3, 32'h000000B7, 32'h12345001);
    checkWord("u_align", 32'h123450B7, 1'b0, 1'b1, 1'b0);
    applyStimulus(3'd4, 32'h000000EF, 32'h00100000);
    checkWord("j_range", 32'h800000EF, 1'b1, 1'b0, 1'b0);
    checkCount("cnt_four", 32'd4);

    // Saturation: a back-to-back stream of 300 illegal-format requests
    for (int n = 0; n < 300; n++) streamReq(3'd7, n, n, ok);
    in_valid = 1'b0;
    drain();
    checkCount("cnt_sat", 32'd255);

    // Backpressure: out_ready is held low for 3 cycles while 4 requests stream
    out_ready = 1'b0;
    acc_n = 0;
    d0 = delivered;
    fork
      begin
        for (int k = 0; k < 4; k++) begin
          bit okk;
          streamReq(3'd0, 32'h00000013 | (k << 7), k * 3, okk);
          if (okk) acc_n++;
        end
        in_valid = 1'b0;
      end
      begin
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
          @(negedge clk);
          if (out_valid) begin
            seen = 1'b1;
            break;
          end
        end
        if (!seen) begin
          timeoutFail("bp_out_valid");
        end else begin
          checkOutput("bp_in_ready", {31'd0, in_ready}, 32'd0);
          checkOutput("bp_accepts", acc_n, 32'd2);
        end
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    checkOutput("bp_delivered", delivered - d0, 32'd4);

    // Reset while two words are in flight
    streamReq(3'd0, 32'h00000093, 32'h00000001, ok);
    streamReq(3'd0, 32'h00000093, 32'h00000002, ok);
    in_valid = 1'b0;
    checkOutput("mid_inflight", {31'd0, out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("mid_err_count", {24'd0, err_count}, 32'd0);
    checkOutput("mid_instr", instr, 32'd0);
    checkOutput("mid_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    applyStimulus(3'd0, 32'h00000093, 32'hFFFFFFFF);
    checkWord("post_rst", 32'hFFF00093, 1'b0, 1'b0, 1'b0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
